// File: rtl/altair_pkg.sv
// Shared types and constants for the Altair memory/DMA arbitration logic.
package altair_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = 255;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN,
        COOLDOWN
    } arb_state_t;
endpackage

// File: rtl/arb_slot_counter.sv
// Saturating up-counter with synchronous clear, count enable and a
// terminal-count flag raised once the count reaches MAX.
module arb_slot_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign tc = (count == MAX_V);

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mem_dma_arbiter.sv
// HOLD/HLDA arbiter sharing the memory port between the i8080 and a DMA master.
// Define ARB_BURST_LIMIT_EN to enable the MAX_BURST / CPU_SLOTS cooldown logic.
module mem_dma_arbiter
    import altair_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int MAX_BURST  = 16,
    parameter int CPU_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_in,
    output logic                  cpu_ce,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic                  cpu_rd,
    input  logic                  cpu_we,
    input  logic                  dma_hold,
    output logic                  dma_hlda,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata
);
    arb_state_t       state, state_nxt;
    logic             dma_sel;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_tc;

    assign dma_sel = (state == GRANT);

`ifdef ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] slot_cnt;
    logic             slot_tc_unused;
    logic             burst_last;

    arb_slot_counter #(.W(CNT_W), .MAX(MAX_BURST)) u_burst_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == IDLE),
        .en      (dma_sel && dma_req),
        .count   (burst_cnt),
        .tc      (burst_tc)
    );

    // Counts CPU enable pulses handed back after a limit-forced release.
    arb_slot_counter #(.W(CNT_W), .MAX(CPU_SLOTS)) u_slot_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != COOLDOWN),
        .en      ((state == COOLDOWN) && ce_in),
        .count   (slot_cnt),
        .tc      (slot_tc_unused)
    );

    // This request is the one that uses up the burst allowance.
    assign burst_last = dma_req && (burst_cnt == CNT_W'(MAX_BURST - 1));
`else
    localparam int unused_cfg = MAX_BURST + CPU_SLOTS;
    logic          unused_burst;

    arb_slot_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_burst_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == IDLE),
        .en      (dma_sel && dma_req),
        .count   (burst_cnt),
        .tc      (burst_tc)
    );

    assign unused_burst = ^{burst_cnt, burst_tc};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            dma_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            dma_ack <= dma_sel && dma_req;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // Grant only on a ce_in edge so the CPU finishes its current step.
            IDLE:  if (dma_hold && ce_in) state_nxt = GRANT;
`ifdef ARB_BURST_LIMIT_EN
            GRANT: if (burst_last || !dma_hold) state_nxt = DRAIN;
            DRAIN: state_nxt = burst_tc ? COOLDOWN : IDLE;
            COOLDOWN:
                if (ce_in && (slot_cnt == CNT_W'(CPU_SLOTS - 1))) state_nxt = IDLE;
`else
            GRANT: if (!dma_hold) state_nxt = DRAIN;
            DRAIN: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign dma_hlda  = dma_sel;
    assign cpu_ce    = reset_n && ce_in && ((state == IDLE) || (state == COOLDOWN));
    assign dma_rdata = mem_rdata;

    assign mem_addr  = dma_sel ? dma_addr  : cpu_addr;
    assign mem_wdata = dma_sel ? dma_wdata : cpu_wdata;
    assign mem_rd    = dma_sel ? (dma_req && !dma_we) : cpu_rd;
    assign mem_we    = dma_sel ? (dma_req &&  dma_we) : cpu_we;
endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Randomized self-checking bench for mem_dma_arbiter against a cycle-level
// behavioural model of bus ownership; honours ARB_BURST_LIMIT_EN if defined.
module tb_mem_dma_arbiter;
    localparam int AW  = 16;
    localparam int MB  = 4;
    localparam int CS  = 2;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, ce_in, cpu_ce;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [7:0]    cpu_wdata, dma_wdata, mem_wdata, dma_rdata, mem_rdata;
    logic          cpu_rd, cpu_we, dma_hold, dma_hlda, dma_req, dma_we, dma_ack;
    logic          mem_rd, mem_we;

    mem_dma_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB), .CPU_SLOTS(CS)) dut (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .cpu_ce(cpu_ce),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
        .dma_hold(dma_hold), .dma_hlda(dma_hlda), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM with one-cycle registered read.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, accesses used this grant,
    // CPU slots handed back, and what an acknowledged read must return.
    int         m_owner;   // 0 cpu, 1 dma, 2 handback cycle, 3 cpu guaranteed slots
    int         m_used, m_slots;
    bit         m_lim, m_ack, m_ack_rd;
    logic [7:0] m_rdata;
    logic [7:0] shadow [0:65535];
    bit         s_ack, s_hlda, s_ce;

    task automatic tick();
        bit         dsel, rd, we;
        logic [AW-1:0] a;
        logic [7:0] wd;
        ce_in = ~ce_in;
        @(negedge clk); #1;
        dsel = (m_owner == 1);
        rd   = dsel ? (dma_req && !dma_we) : cpu_rd;
        we   = dsel ? (dma_req &&  dma_we) : cpu_we;
        a    = dsel ? dma_addr  : cpu_addr;
        wd   = dsel ? dma_wdata : cpu_wdata;
        chk("cpu_ce", cpu_ce, reset_n && ce_in && (m_owner == 0 || m_owner == 3));
        chk("hlda", dma_hlda, dsel);
        chk("ack", dma_ack, m_ack);
        chk("mem_rd", mem_rd, rd);
        chk("mem_we", mem_we, we);
        if (rd || we) chk("mem_addr", mem_addr, a);
        if (we) chk("mem_wdata", mem_wdata, wd);
        if (m_ack && m_ack_rd) chk("rdata", dma_rdata, m_rdata);
        s_ack = dma_ack; s_hlda = dma_hlda; s_ce = cpu_ce;
        if (rd) m_rdata = shadow[a];
        if (we) shadow[a] = wd;
        if (!reset_n) begin
            m_owner = 0; m_used = 0; m_slots = 0; m_lim = 0; m_ack = 0; m_ack_rd = 0;
        end else begin
            m_ack    = dsel && dma_req;
            m_ack_rd = m_ack && !dma_we;
            case (m_owner)
                0: begin
                    m_used = 0;
                    if (dma_hold && ce_in) m_owner = 1;
                end
                1: begin
                    if (dma_req && m_used < 255) m_used++;
                    if (LIM && m_used == MB) begin m_owner = 2; m_lim = 1; end
                    else if (!dma_hold) begin m_owner = 2; m_lim = 0; end
                end
                2: begin m_owner = m_lim ? 3 : 0; m_slots = 0; end
                default: begin
                    if (ce_in) m_slots++;
                    if (m_slots == CS) m_owner = 0;
                end
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (!s_hlda && lat < 10) begin tick(); if (!s_hlda) lat++; end
        if (!s_hlda) chk("grant_timeout", 0, 1);
    endtask

    task automatic release_bus();
        int n = 0;
        dma_hold = 0; dma_req = 0;
        do begin tick(); n++; end while ((m_owner != 0 || s_hlda) && n < 30);
        if (m_owner != 0) chk("release_timeout", 0, 1);
    endtask

    initial begin
        int lat, exp_lat, acks, pulses, phase;
        for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
        mem_rdata = 8'h00; m_rdata = 8'h00;
        m_owner = 0; m_used = 0; m_slots = 0; m_lim = 0; m_ack = 0; m_ack_rd = 0;
        reset_n = 0; ce_in = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h11;
        cpu_rd = 0; cpu_we = 0; dma_hold = 1; dma_req = 0; dma_we = 0;
        dma_addr = 0; dma_wdata = 0;

        // Reset with hold asserted: nothing may be granted or enabled.
        repeat (3) tick();
        chk("rst_hlda", s_hlda, 0);
        chk("rst_ce", s_ce, 0);
        chk("rst_ack", s_ack, 0);
        reset_n = 1;
        exp_lat = (ce_in == 0) ? 1 : 2;   // next tick drives ~ce_in
        wait_grant(lat);
        chk("grant_after_reset", lat, exp_lat);

        // Back-to-back DMA write then read of the same location.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 8'hA5;
        tick();
        chk("wr_strobe", {mem_we, mem_rd}, 2'b10);
        dma_we = 0;
        tick();
        chk("wr_ack", s_ack, 1);
        dma_req = 0;
        tick();
        chk("rd_ack", s_ack, 1);
        chk("rd_a5", dma_rdata, 8'hA5);

        // Grant alignment: hold raised while ce_in is low takes two cycles.
        release_bus();
        if (ce_in == 0) tick();
        dma_hold = 1;
        wait_grant(lat);
        chk("grant_align", lat, 2);
        repeat (3) begin tick(); chk("frozen_ce", s_ce, 0); end

        // Continuous requests from a fresh grant.
        release_bus();
        dma_hold = 1;
        wait_grant(lat);
        acks = 0; pulses = 0; phase = 0;
        for (int i = 0; i < 40 && phase < 2; i++) begin
            dma_req = (i < 10); dma_we = 0; dma_addr = 16'($urandom_range(0, 15));
            tick();
            if (phase == 0) begin
                if (s_ack) acks++;
                if (!s_hlda) phase = 1;
            end else if (phase == 1) begin
                if (s_hlda) phase = 2;
                else if (s_ce) pulses++;
            end
            if (!LIM && i >= 11) break;
        end
        dma_req = 0;
        if (LIM) begin
            chk("burst_acks", acks, MB);
            // CPU_SLOTS cooldown pulses plus the step completed on the regrant edge.
            chk("cooldown_pulses", pulses, CS + 1);
            chk("regrant", phase, 2);
        end else begin
            chk("burst_acks", acks, 10);
            chk("no_release", phase, 0);
        end

        // Hold dropped together with a request: ack lands in the drain cycle.
        if (!s_hlda) wait_grant(lat);
        dma_hold = 0; dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'h3C;
        tick();
        dma_req = 0;
        tick();
        chk("drain_ack", s_ack, 1);
        chk("drain_hlda", s_hlda, 0);
        lat = 0;
        do begin tick(); lat++; end while (!s_ce && lat < 20);
        chk("cpu_resumes", s_ce, 1);

        // Random traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) dma_hold = ~dma_hold;
            dma_req   = $urandom_range(0, 1);
            dma_we    = $urandom_range(0, 1);
            dma_addr  = 16'($urandom_range(0, 15)) | 16'h0100;
            dma_wdata = 8'($urandom);
            cpu_rd    = $urandom_range(0, 1);
            cpu_we    = !cpu_rd && ($urandom_range(0, 3) == 0);
            cpu_addr  = 16'($urandom_range(0, 15)) | 16'h0100;
            cpu_wdata = 8'($urandom);
            reset_n   = !(i == 200 || (i > 200 && i < 260 && m_owner == 1 && reset_n == 1 && i == 230));
            tick();
        end
        reset_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
